// File: rtl/prirv32_pkg.sv
// prirv32_pkg: shared definitions for the prirv32 front end and execute stage.
//   - RV32I opcode and funct3 constants
//   - FSM state encoding of the instruction decode unit
//   - packed class-flag bundle produced by the decoder
//   - immediate format selection helper used by the immediate generator
package prirv32_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;

    // funct3 values (instr[14:12])
    localparam logic [2:0] F3_JALR  = 3'b000;
    localparam logic [2:0] F3_PRIV  = 3'b000;  // ECALL/EBREAK within SYSTEM
    localparam logic [2:0] F3_BEQ   = 3'b000;
    localparam logic [2:0] F3_BNE   = 3'b001;
    localparam logic [2:0] F3_BLT   = 3'b100;
    localparam logic [2:0] F3_BGE   = 3'b101;
    localparam logic [2:0] F3_BLTU  = 3'b110;
    localparam logic [2:0] F3_BGEU  = 3'b111;
    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SLT   = 3'b010;
    localparam logic [2:0] F3_SLTU  = 3'b011;
    localparam logic [2:0] F3_XOR   = 3'b100;
    localparam logic [2:0] F3_SR    = 3'b101;
    localparam logic [2:0] F3_OR    = 3'b110;
    localparam logic [2:0] F3_AND   = 3'b111;

    // Decode unit sequencing
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_ISSUE  = 2'd2
    } idu_state_e;

    // Immediate encodings
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // Instruction class flags, MSB first
    typedef struct packed {
        logic load;
        logic store;
        logic branch;
        logic alu_imm;
        logic alu_reg;
        logic fence;
        logic csr;
        logic illegal;
    } dec_flags_t;

    // Select the immediate layout; encodings without an immediate
    // (R-type, fence, illegal) map to IMM_NONE and yield zero.
    function automatic imm_fmt_e imm_format(input logic [31:0] instr);
        imm_fmt_e fmt;
        fmt = IMM_NONE;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: fmt = IMM_I;
            OPC_JALR: begin
                if (instr[14:12] == F3_JALR) begin
                    fmt = IMM_I;
                end else begin
                    fmt = IMM_NONE;
                end
            end
            OPC_STORE:           fmt = IMM_S;
            OPC_BRANCH:          fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:  fmt = IMM_U;
            OPC_JAL:             fmt = IMM_J;
            default:             fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/prirv32_immgen.sv
// prirv32_immgen: combinational RV32I immediate generator.
//   instr in  32 : raw instruction word
//   imm   out 32 : sign-extended immediate (zero for formats without one)
import prirv32_pkg::*;

module prirv32_immgen (
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    imm_fmt_e imm_fmt_s;

    // Assemble the immediate bits for the selected format
    always_comb begin
        imm_fmt_s = imm_format(instr);
        imm       = 32'h0000_0000;
        case (imm_fmt_s)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'h000};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/prirv32_idu.sv
// prirv32_idu: instruction fetch/decode unit, FETCH -> DECODE -> ISSUE.
//   clk_in, rst_n                : clock, asynchronous active-low reset
//   mem_valid/mem_addr           : fetch request and word address (held while pending)
//   mem_ready/mem_rdata          : fetch completion and instruction word
//   redirect_valid/redirect_pc   : flush and restart fetch at redirect_pc (bits [1:0] dropped)
//   rs1_addr/rs2_addr            : register-file read indices taken from the fetched word
//   rf_rdata1/rf_rdata2          : combinational register-file read data
//   dec_valid/exu_ready          : issue handshake towards execute
//   pc_decoded ... rd_decoded    : decoded bundle, held stable while dec_valid=1
//   is_* / illegal_instr         : instruction class flags
import prirv32_pkg::*;

module prirv32_idu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        dec_valid,
    input  logic        exu_ready,
    output logic [31:0] pc_decoded,
    output logic [31:0] datafetch_latched,
    output logic [31:0] imm_decoded,
    output logic [31:0] rs1_decoded,
    output logic [31:0] rs2_decoded,
    output logic [4:0]  rd_decoded,
    output logic        is_lb_lh_lw_lbu_lhu,
    output logic        is_sb_sh_sw,
    output logic        is_beq_bne_blt_bge_bltu_bgeu,
    output logic        is_alu_reg_imm,
    output logic        is_alu_reg_reg,
    output logic        is_fence_fencei,
    output logic        is_csr_access,
    output logic        illegal_instr
);

    idu_state_e  state_r;
    logic [31:0] pc_r;
    logic        mem_valid_r;
    logic [31:0] instr_r;
    logic        dec_valid_r;
    logic [31:0] pc_dec_r;
    logic [31:0] imm_r;
    logic [31:0] rs1_r;
    logic [31:0] rs2_r;
    logic [4:0]  rd_r;
    dec_flags_t  flags_r;

    logic [31:0] imm_s;
    dec_flags_t  flags_s;
    logic [4:0]  rd_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;

    prirv32_immgen u_immgen (
        .instr (instr_r),
        .imm   (imm_s)
    );

    // Register indices come straight from the latched word so the register
    // file answers within the DECODE cycle.
    assign rs1_addr = instr_r[19:15];
    assign rs2_addr = instr_r[24:20];

    // Classify the latched instruction and pick the destination register
    always_comb begin
        opcode_s = instr_r[6:0];
        funct3_s = instr_r[14:12];
        flags_s  = '0;
        rd_s     = instr_r[11:7];
        case (opcode_s)
            OPC_LOAD:     flags_s.load    = 1'b1;
            OPC_STORE: begin
                flags_s.store = 1'b1;
                rd_s          = 5'd0;
            end
            OPC_BRANCH: begin
                flags_s.branch = 1'b1;
                rd_s           = 5'd0;
            end
            OPC_OP_IMM:   flags_s.alu_imm = 1'b1;
            OPC_OP:       flags_s.alu_reg = 1'b1;
            OPC_MISC_MEM: flags_s.fence   = 1'b1;
            OPC_SYSTEM: begin
                // funct3 == 0 is ECALL/EBREAK: legal but carries no class
                if (funct3_s != F3_PRIV) begin
                    flags_s.csr = 1'b1;
                end else begin
                    flags_s.csr = 1'b0;
                end
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: flags_s = '0;
            OPC_JALR: begin
                if (funct3_s != F3_JALR) begin
                    flags_s.illegal = 1'b1;
                end else begin
                    flags_s.illegal = 1'b0;
                end
            end
            default:      flags_s.illegal = 1'b1;
        endcase
    end

    // x0 always reads as zero regardless of what the register file returns
    always_comb begin
        if (rs1_addr == 5'd0) begin
            rs1_val_s = 32'h0000_0000;
        end else begin
            rs1_val_s = rf_rdata1;
        end
        if (rs2_addr == 5'd0) begin
            rs2_val_s = 32'h0000_0000;
        end else begin
            rs2_val_s = rf_rdata2;
        end
    end

    // Fetch/decode/issue sequencer; a redirect overrides every state and
    // discards any coinciding fetch completion or issue acceptance.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FETCH;
            pc_r        <= RESET_PC;
            mem_valid_r <= 1'b0;
            instr_r     <= 32'h0000_0000;
            dec_valid_r <= 1'b0;
            pc_dec_r    <= 32'h0000_0000;
            imm_r       <= 32'h0000_0000;
            rs1_r       <= 32'h0000_0000;
            rs2_r       <= 32'h0000_0000;
            rd_r        <= 5'd0;
            flags_r     <= '0;
        end else if (redirect_valid) begin
            state_r     <= ST_FETCH;
            pc_r        <= redirect_pc & 32'hFFFF_FFFC;
            mem_valid_r <= 1'b1;
            dec_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    // mem_valid_r is low only in the first cycle out of reset
                    if (mem_valid_r && mem_ready) begin
                        instr_r     <= mem_rdata;
                        mem_valid_r <= 1'b0;
                        state_r     <= ST_DECODE;
                    end else begin
                        mem_valid_r <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    pc_dec_r    <= pc_r;
                    imm_r       <= imm_s;
                    rs1_r       <= rs1_val_s;
                    rs2_r       <= rs2_val_s;
                    rd_r        <= rd_s;
                    flags_r     <= flags_s;
                    dec_valid_r <= 1'b1;
                    state_r     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (exu_ready) begin
                        dec_valid_r <= 1'b0;
                        pc_r        <= pc_r + 32'd4;
                        mem_valid_r <= 1'b1;
                        state_r     <= ST_FETCH;
                    end else begin
                        dec_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_FETCH;
                    mem_valid_r <= 1'b0;
                    dec_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_valid         = mem_valid_r;
    assign mem_addr          = pc_r;
    assign dec_valid         = dec_valid_r;
    assign pc_decoded        = pc_dec_r;
    assign datafetch_latched = instr_r;
    assign imm_decoded       = imm_r;
    assign rs1_decoded       = rs1_r;
    assign rs2_decoded       = rs2_r;
    assign rd_decoded        = rd_r;

    assign is_lb_lh_lw_lbu_lhu          = flags_r.load;
    assign is_sb_sh_sw                  = flags_r.store;
    assign is_beq_bne_blt_bge_bltu_bgeu = flags_r.branch;
    assign is_alu_reg_imm               = flags_r.alu_imm;
    assign is_alu_reg_reg               = flags_r.alu_reg;
    assign is_fence_fencei              = flags_r.fence;
    assign is_csr_access                = flags_r.csr;
    assign illegal_instr                = flags_r.illegal;

endmodule

// File: tb/tb_prirv32_idu.sv
// tb_prirv32_idu: directed, table-driven bench for prirv32_idu.
module tb_prirv32_idu;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [7:0]  flags;  // {load,store,branch,alu_imm,alu_reg,fence,csr,illegal}
        int          wait_c;
        int          hold_c;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        dec_valid;
    logic        exu_ready;
    logic [31:0] pc_decoded;
    logic [31:0] datafetch_latched;
    logic [31:0] imm_decoded;
    logic [31:0] rs1_decoded;
    logic [31:0] rs2_decoded;
    logic [4:0]  rd_decoded;
    logic        is_lb_lh_lw_lbu_lhu;
    logic        is_sb_sh_sw;
    logic        is_beq_bne_blt_bge_bltu_bgeu;
    logic        is_alu_reg_imm;
    logic        is_alu_reg_reg;
    logic        is_fence_fencei;
    logic        is_csr_access;
    logic        illegal_instr;
    logic [7:0]  dut_flags;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_pc;
    vec_t        vecs[14];
    vec_t        nop;

    prirv32_idu #(.RESET_PC(32'h0000_0100)) dut (
        .clk_in                       (clk_in),
        .rst_n                        (rst_n),
        .mem_valid                    (mem_valid),
        .mem_addr                     (mem_addr),
        .mem_ready                    (mem_ready),
        .mem_rdata                    (mem_rdata),
        .redirect_valid               (redirect_valid),
        .redirect_pc                  (redirect_pc),
        .rs1_addr                     (rs1_addr),
        .rs2_addr                     (rs2_addr),
        .rf_rdata1                    (rf_rdata1),
        .rf_rdata2                    (rf_rdata2),
        .dec_valid                    (dec_valid),
        .exu_ready                    (exu_ready),
        .pc_decoded                   (pc_decoded),
        .datafetch_latched            (datafetch_latched),
        .imm_decoded                  (imm_decoded),
        .rs1_decoded                  (rs1_decoded),
        .rs2_decoded                  (rs2_decoded),
        .rd_decoded                   (rd_decoded),
        .is_lb_lh_lw_lbu_lhu          (is_lb_lh_lw_lbu_lhu),
        .is_sb_sh_sw                  (is_sb_sh_sw),
        .is_beq_bne_blt_bge_bltu_bgeu (is_beq_bne_blt_bge_bltu_bgeu),
        .is_alu_reg_imm               (is_alu_reg_imm),
        .is_alu_reg_reg               (is_alu_reg_reg),
        .is_fence_fencei              (is_fence_fencei),
        .is_csr_access                (is_csr_access),
        .illegal_instr                (illegal_instr)
    );

    // Register-file model: every register holds a value derived from its index
    function automatic logic [31:0] rf_val(input logic [4:0] idx);
        return {8'hA5, 3'b000, idx, 8'h3C, 3'b000, idx};
    endfunction

    assign rf_rdata1 = rf_val(rs1_addr);
    assign rf_rdata2 = rf_val(rs2_addr);
    assign dut_flags = {is_lb_lh_lw_lbu_lhu, is_sb_sh_sw, is_beq_bne_blt_bge_bltu_bgeu,
                        is_alu_reg_imm, is_alu_reg_reg, is_fence_fencei,
                        is_csr_access, illegal_instr};

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (!mem_valid && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        chk("fetch_request", {31'd0, mem_valid}, 32'd1);
    endtask

    function automatic logic [31:0] exp_rs(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : rf_val(idx);
    endfunction

    task automatic check_bundle(input vec_t v);
        chk("dec_valid", {31'd0, dec_valid}, 32'd1);
        chk("pc_decoded", pc_decoded, exp_pc);
        chk("datafetch", datafetch_latched, v.instr);
        chk("imm", imm_decoded, v.imm);
        chk("rd", {27'd0, rd_decoded}, {27'd0, v.rd});
        chk("flags", {24'd0, dut_flags}, {24'd0, v.flags});
        chk("rs1_val", rs1_decoded, exp_rs(v.instr[19:15]));
        chk("rs2_val", rs2_decoded, exp_rs(v.instr[24:20]));
    endtask

    // Fetch v and stop at the first ISSUE cycle (negedge, dec_valid expected 1)
    task automatic fetch_to_issue(input vec_t v);
        wait_fetch();
        chk("mem_addr", mem_addr, exp_pc);
        for (int w = 0; w < v.wait_c; w++) begin
            @(negedge clk_in);
            chk("wait_valid", {31'd0, mem_valid}, 32'd1);
            chk("wait_addr", mem_addr, exp_pc);
        end
        mem_ready = 1'b1;
        mem_rdata = v.instr;
        @(negedge clk_in);
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        chk("decode_no_valid", {31'd0, dec_valid}, 32'd0);
        chk("decode_no_fetch", {31'd0, mem_valid}, 32'd0);
        @(negedge clk_in);
    endtask

    task automatic accept(input vec_t v);
        for (int h = 0; h < v.hold_c; h++) begin
            @(negedge clk_in);
            check_bundle(v);
        end
        exu_ready = 1'b1;
        @(negedge clk_in);
        exu_ready = 1'b0;
        exp_pc = exp_pc + 32'd4;
        chk("post_accept_valid", {31'd0, dec_valid}, 32'd0);
        chk("post_accept_fetch", {31'd0, mem_valid}, 32'd1);
        chk("post_accept_addr", mem_addr, exp_pc);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h0050_0093, 32'h0000_0005, 5'd1, 8'h10, 1, 0};  // addi x1,x0,5
        vecs[1]  = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 5'd0, 8'h20, 0, 3};  // beq x0,x0,-4
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0000, 5'd31, 8'h01, 0, 1}; // illegal
        vecs[3]  = '{32'h1234_5037, 32'h1234_5000, 5'd0, 8'h00, 2, 0};  // lui
        vecs[4]  = '{32'hFF81_2283, 32'hFFFF_FFF8, 5'd5, 8'h80, 0, 1};  // lw x5,-8(x2)
        vecs[5]  = '{32'h0063_A623, 32'h0000_000C, 5'd0, 8'h40, 1, 0};  // sw x6,12(x7)
        vecs[6]  = '{32'h0020_81B3, 32'h0000_0000, 5'd3, 8'h08, 0, 2};  // add x3,x1,x2
        vecs[7]  = '{32'h0FF0_000F, 32'h0000_0000, 5'd0, 8'h04, 0, 0};  // fence
        vecs[8]  = '{32'h3001_10F3, 32'h0000_0300, 5'd1, 8'h02, 1, 1};  // csrrw x1,0x300,x2
        vecs[9]  = '{32'h0000_0073, 32'h0000_0000, 5'd0, 8'h00, 0, 0};  // ecall
        vecs[10] = '{32'hFFDF_F0EF, 32'hFFFF_FFFC, 5'd1, 8'h00, 0, 0};  // jal x1,-4
        vecs[11] = '{32'hFFF0_8167, 32'hFFFF_FFFF, 5'd2, 8'h00, 1, 0};  // jalr x2,-1(x1)
        vecs[12] = '{32'hFFF0_9167, 32'h0000_0000, 5'd2, 8'h01, 0, 0};  // jalr funct3=1
        vecs[13] = '{32'h8000_0217, 32'h8000_0000, 5'd4, 8'h00, 0, 1};  // auipc x4
        nop      = '{32'h0000_0013, 32'h0000_0000, 5'd0, 8'h10, 0, 0};  // addi x0,x0,0

        rst_n          = 1'b0;
        mem_ready      = 1'b0;
        mem_rdata      = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        exu_ready      = 1'b0;
        exp_pc         = 32'h0000_0100;

        // Held in reset
        repeat (3) @(negedge clk_in);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_pc", mem_addr, 32'h0000_0100);
        chk("rst_imm", imm_decoded, 32'h0);
        chk("rst_flags", {24'd0, dut_flags}, 32'h0);
        chk("rst_instr", datafetch_latched, 32'h0);
        rst_n = 1'b1;
        @(negedge clk_in);
        chk("first_cycle_valid", {31'd0, mem_valid}, 32'd1);

        // Table: fetch, decode, issue, accept
        for (int i = 0; i < 14; i++) begin
            fetch_to_issue(vecs[i]);
            check_bundle(vecs[i]);
            accept(vecs[i]);
        end

        // Redirect coinciding with fetch completion drops the word
        wait_fetch();
        mem_ready      = 1'b1;
        mem_rdata      = 32'h0050_0093;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        @(negedge clk_in);
        mem_ready      = 1'b0;
        redirect_valid = 1'b0;
        exp_pc         = 32'h0000_0200;
        chk("redir_addr", mem_addr, 32'h0000_0200);
        chk("redir_fetch", {31'd0, mem_valid}, 32'd1);
        chk("redir_no_valid", {31'd0, dec_valid}, 32'd0);
        @(negedge clk_in);
        chk("redir_no_valid2", {31'd0, dec_valid}, 32'd0);
        chk("redir_addr2", mem_addr, 32'h0000_0200);

        // Redirect together with exu_ready: target wins, no +4
        fetch_to_issue(nop);
        check_bundle(nop);
        exu_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        @(negedge clk_in);
        exu_ready      = 1'b0;
        redirect_valid = 1'b0;
        exp_pc         = 32'h0000_0400;
        chk("issue_redir_addr", mem_addr, 32'h0000_0400);
        chk("issue_redir_valid", {31'd0, dec_valid}, 32'd0);

        // PC wrap-around at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk_in);
        redirect_valid = 1'b0;
        exp_pc         = 32'hFFFF_FFFC;
        fetch_to_issue(nop);
        check_bundle(nop);
        accept(nop);
        chk("wrap_addr", mem_addr, 32'h0000_0000);

        // Reset asserted mid-issue clears dec_valid immediately
        fetch_to_issue(vecs[0]);
        check_bundle(vecs[0]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_issue_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_issue_fetch", {31'd0, mem_valid}, 32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        chk("rerst_valid", {31'd0, dec_valid}, 32'd0);
        chk("rerst_fetch", {31'd0, mem_valid}, 32'd1);
        chk("rerst_addr", mem_addr, 32'h0000_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prirv32_idu.md
PRIRV32_IDU -- requirements
Module: prirv32_idu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset; bits [1:0] SHALL be 0.
REQ-002 SHALL have ports clk_in in 1 (the single clock) and rst_n in 1 (reset, asynchronous, active-low).
REQ-003 SHALL have fetch ports: mem_valid out 1 (fetch request); mem_addr out 32 (fetch address); mem_ready in 1 (rdata valid, request done); mem_rdata in 32 (instruction word).
REQ-004 SHALL have redirect ports: redirect_valid in 1 (flush and load new PC); redirect_pc in 32 (target).
REQ-005 SHALL have register-file ports: rs1_addr out 5, rs2_addr out 5 (read indices); rf_rdata1 in 32, rf_rdata2 in 32 (combinational read data).
REQ-006 SHALL have issue handshake ports: dec_valid out 1 (decoded bundle valid); exu_ready in 1 (execute accepts the bundle).
REQ-007 SHALL have bundle outputs: pc_decoded 32; datafetch_latched 32 (raw instruction); imm_decoded 32; rs1_decoded 32; rs2_decoded 32; rd_decoded 5.
REQ-008 SHALL have class flags, 1 bit each: is_lb_lh_lw_lbu_lhu, is_sb_sh_sw, is_beq_bne_blt_bge_bltu_bgeu, is_alu_reg_imm, is_alu_reg_reg, is_fence_fencei, is_csr_access, illegal_instr.

Function
REQ-009 SHALL implement FSM FETCH -> DECODE -> ISSUE -> FETCH.
REQ-010 FETCH: mem_valid=1, mem_addr=pc; on mem_ready, latch mem_rdata into datafetch_latched and go to DECODE.
REQ-011 DECODE: last one cycle; drive rs1_addr=instr[19:15] and rs2_addr=instr[24:20]; register imm, flags, rd and operands; go to ISSUE.
REQ-012 rs1_decoded/rs2_decoded SHALL be 0 when the index is 0, else rf_rdata1/rf_rdata2 sampled in DECODE.
REQ-013 ISSUE: dec_valid=1 with all bundle outputs stable until exu_ready=1; on that cycle pc<=pc+4 (mod 2^32) and go to FETCH.
REQ-014 Latency: mem_ready in cycle N SHALL give dec_valid=1 in cycle N+2.
REQ-015 Class decode by opcode[6:0]:
- 0000011 -> load
- 0100011 -> store
- 1100011 -> branch
- 0010011 -> alu_reg_imm
- 0110011 -> alu_reg_reg
- 0001111 -> fence
- 1110011 with funct3!=0 -> csr
REQ-016 LUI, AUIPC, JAL, JALR (funct3=0) and ECALL/EBREAK SHALL be legal with no class flag set.
REQ-017 Any other encoding SHALL set illegal_instr=1 with all class flags 0; it is still issued normally.
REQ-018 imm_decoded SHALL be sign-extended per format:
- I: load, alu_reg_imm, JALR, SYSTEM
- S: store
- B: branch, bit0=0
- U: LUI/AUIPC, low 12 bits 0
- J: JAL, bit0=0
- fence and illegal: 0
REQ-019 rd_decoded SHALL be instr[11:7] for all formats, 0 for store and branch.
REQ-020 redirect_valid SHALL win in any state: next cycle pc=redirect_pc with bits [1:0] cleared, state=FETCH, dec_valid=0.
REQ-021 A mem_ready coinciding with redirect_valid SHALL be discarded.
REQ-022 exu_ready coinciding with redirect_valid SHALL not increment pc.
REQ-023 mem_valid SHALL deassert only on acceptance or redirect; mem_addr SHALL be stable while mem_valid=1.

Reset
REQ-024 On rst_n=0, asynchronously: state=FETCH, pc=RESET_PC, dec_valid=0, all bundle outputs and flags 0.
REQ-025 mem_valid SHALL be 0 while in reset and 1 in the first cycle after release.
REQ-026 Reset mid-fetch or mid-issue SHALL abandon the transaction without a residual dec_valid.

Structure
REQ-027 Opcode constants, funct3 constants and FSM state encodings SHALL reside in shared package prirv32_pkg, reused by the execute stage.
REQ-028 Immediate generation SHALL be one combinational sub-module prirv32_immgen (instr in 32, imm out 32); no other sub-modules.

Verification
REQ-029 Reset release, RESET_PC=0x100, mem_ready after 1 wait cycle with 0x00500093 (addi x1,x0,5) -> mem_addr=0x100, then dec_valid 2 cycles after mem_ready with is_alu_reg_imm=1, imm=5, rd=1, rs1_decoded=0, pc_decoded=0x100.
REQ-030 Issue 0xFE000EE3 (beq x0,x0,-4) with exu_ready held 0 for 3 cycles -> bundle stable, imm=0xFFFFFFFC, rd=0; after accept mem_addr=pc+4.
REQ-031 Redirect to 0x203 asserted in the same cycle as mem_ready -> fetched word dropped, next mem_addr=0x200, no dec_valid.
REQ-032 Fetch 0xFFFFFFFF -> illegal_instr=1, all class flags 0, dec_valid=1; then 0x12345037 (lui) -> imm=0x12345000, no flags.
REQ-033 pc=0xFFFFFFFC accepted -> next mem_addr=0x00000000; rst_n pulsed low during ISSUE -> dec_valid=0 immediately.
